assoc_branch_predictor: RTL and testbench
=========================================

ASSOC_BRANCH_PREDICTOR -- requirements
Module: assoc_branch_predictor

Interface
REQ-001 Parameter DATA_WIDTH, default 32, PC and target width in bits.
REQ-002 Parameter LINE_NUM, default 8, entry count; power of two, 2..32.
REQ-003 Parameter TAG_WIDTH, default 10, tag = pc[TAG_WIDTH+1:2]; TAG_WIDTH+2 <= DATA_WIDTH.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  update enable; low blocks all table writes except rst and flush.
REQ-007 flush  input  1  invalidate all entries.
REQ-008 lookup_pc  input  DATA_WIDTH  fetch-stage PC to predict.
REQ-009 pred_hit  output  1  lookup_pc tag matches a valid entry.
REQ-010 pred_taken  output  1  prediction taken.
REQ-011 pred_target  output  DATA_WIDTH  predicted next PC.
REQ-012 upd_valid  input  1  resolved branch present this cycle.
REQ-013 upd_pc  input  DATA_WIDTH  PC of resolved branch.
REQ-014 upd_taken  input  1  actual outcome.
REQ-015 upd_target  input  DATA_WIDTH  actual branch target.

Function
REQ-016 Storage per entry: valid, tag (TAG_WIDTH), target (full DATA_WIDTH), 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST), age (log2 LINE_NUM bits).
REQ-017 Lookup combinational, zero latency: hit = valid & tag match; at most one entry matches by construction.
REQ-018 pred_taken = pred_hit & counter[1]; pred_target = (pred_taken) ? entry target : lookup_pc + 4, modulo 2^DATA_WIDTH.
REQ-019 Lookup reflects pre-edge state; no bypass from a same-cycle update.
REQ-020 Update acts only when upd_valid & en & ~flush & ~rst.
REQ-021 Update hit: counter saturating +1 if upd_taken else -1 (11 stays 11, 00 stays 00); target overwritten with upd_target only if upd_taken; entry touched (REQ-024).
REQ-022 Update miss, upd_taken=1: allocate victim; valid=1, tag, target=upd_target, counter=10 (WT); victim touched.
REQ-023 Update miss, upd_taken=0: no table or age change.
REQ-024 Victim selection: lowest-index invalid entry if any; else the entry with age LINE_NUM-1 (true LRU).
REQ-025 Touch of entry k with age a: every entry with age < a increments, entry k age := 0; ages remain a permutation of 0..LINE_NUM-1 at all times.
REQ-026 Lookups never alter ages or counters.
REQ-027 flush clears all valid bits in one cycle; ages, counters, tags, targets unchanged; same-cycle update ignored.
REQ-028 Priority: rst > flush > update.

Reset
REQ-029 On rst: all valid=0, counters=10, tags=0, targets=0, age[i]=i.
REQ-030 During and after rst, with no update: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
REQ-031 rst asserted mid-operation discards any same-cycle update.

Verification (LINE_NUM=4, TAG_WIDTH=10)
REQ-032 After rst, lookup_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104.
REQ-033 Update pc=0x100 taken target=0x200, next cycle lookup 0x100 -> hit=1, taken=1, target=0x200; update not-taken twice -> counter 00, lookup gives taken=0, target=0x104; three taken updates -> counter 11, fourth taken stays 11.
REQ-034 Allocate taken branches 0x10,0x20,0x30,0x40 (entries 0..3), update hit 0x10, then allocate 0x50 -> replaces 0x20's entry; lookup 0x20 miss, 0x10 and 0x50 hit.
REQ-035 Update not-taken miss pc=0x60 -> no allocation, lookup 0x60 miss, ages unchanged.
REQ-036 flush with simultaneous update pc=0x70 taken -> all lookups miss next cycle, 0x70 not allocated; en=0 with upd_valid=1 -> no change.
REQ-037 Same cycle lookup 0x80 and first taken update 0x80 -> pred_hit=0 that cycle, 1 next cycle.

Source files
------------

// File: rtl/assoc_branch_predictor_if.sv
// Branch predictor lookup/update bus.
//   master : fetch/resolve side -- drives lookup_pc and the upd_* group,
//            receives the pred_* group.
//   slave  : predictor side -- receives lookup_pc and upd_*, drives pred_*.
interface assoc_branch_predictor_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] lookup_pc;
    logic                  pred_hit;
    logic                  pred_taken;
    logic [DATA_WIDTH-1:0] pred_target;
    logic                  upd_valid;
    logic [DATA_WIDTH-1:0] upd_pc;
    logic                  upd_taken;
    logic [DATA_WIDTH-1:0] upd_target;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
        input  pred_hit, pred_taken, pred_target
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
        output pred_hit, pred_taken, pred_target
    );
endinterface

// File: rtl/assoc_branch_predictor.sv
// Fully associative branch target predictor with 2-bit saturating counters
// and true-LRU replacement.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset
//   en    : update enable (does not gate rst or flush)
//   flush : invalidate every entry in one cycle
//   bp    : slave side of the lookup/update bus
//           lookup_pc -> pred_hit/pred_taken/pred_target (combinational)
//           upd_valid/upd_pc/upd_taken/upd_target (resolved branch)
module assoc_branch_predictor #(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_NUM   = 8,
    parameter int TAG_WIDTH  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      flush,
    assoc_branch_predictor_if.slave   bp
);
    localparam int IDX_W = $clog2(LINE_NUM);

    logic [LINE_NUM-1:0]   valid_q, valid_d;
    logic [TAG_WIDTH-1:0]  tag_q    [LINE_NUM];
    logic [TAG_WIDTH-1:0]  tag_d    [LINE_NUM];
    logic [DATA_WIDTH-1:0] target_q [LINE_NUM];
    logic [DATA_WIDTH-1:0] target_d [LINE_NUM];
    logic [1:0]            ctr_q    [LINE_NUM];
    logic [1:0]            ctr_d    [LINE_NUM];
    logic [IDX_W-1:0]      age_q    [LINE_NUM];
    logic [IDX_W-1:0]      age_d    [LINE_NUM];

    logic [TAG_WIDTH-1:0] look_tag, upd_tag;
    logic                 look_hit, upd_hit, found_inv, touch;
    logic [IDX_W-1:0]     look_idx, upd_idx, victim_idx, touch_idx, touch_age;
    logic                 unused_upd_pc;

    assign look_tag      = bp.lookup_pc[TAG_WIDTH+1:2];
    assign upd_tag       = bp.upd_pc[TAG_WIDTH+1:2];
    assign unused_upd_pc = ^bp.upd_pc;

    // Tags are unique across valid entries, so at most one index matches.
    always_comb begin
        look_hit = 1'b0;
        look_idx = '0;
        upd_hit  = 1'b0;
        upd_idx  = '0;
        for (int unsigned i = 0; i < LINE_NUM; i++) begin
            if (valid_q[i] && tag_q[i] == look_tag) begin
                look_hit = 1'b1;
                look_idx = IDX_W'(i);
            end
            if (valid_q[i] && tag_q[i] == upd_tag) begin
                upd_hit = 1'b1;
                upd_idx = IDX_W'(i);
            end
        end
    end

    assign bp.pred_hit    = look_hit;
    assign bp.pred_taken  = look_hit & ctr_q[look_idx][1];
    assign bp.pred_target = (look_hit && ctr_q[look_idx][1]) ? target_q[look_idx]
                                                             : bp.lookup_pc + DATA_WIDTH'(4);

    // Victim: lowest-index invalid entry, otherwise the oldest (age LINE_NUM-1).
    always_comb begin
        found_inv  = 1'b0;
        victim_idx = '0;
        for (int unsigned i = 0; i < LINE_NUM; i++) begin
            if (!found_inv && !valid_q[i]) begin
                found_inv  = 1'b1;
                victim_idx = IDX_W'(i);
            end
        end
        if (!found_inv) begin
            for (int unsigned i = 0; i < LINE_NUM; i++) begin
                if (age_q[i] == IDX_W'(LINE_NUM - 1)) begin
                    victim_idx = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        age_d     = age_q;
        touch     = 1'b0;
        touch_idx = '0;
        if (flush) begin
            valid_d = '0;
        end else if (bp.upd_valid && en) begin
            if (upd_hit) begin
                touch     = 1'b1;
                touch_idx = upd_idx;
                if (bp.upd_taken) begin
                    target_d[upd_idx] = bp.upd_target;
                    if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'b01;
                end else begin
                    if (ctr_q[upd_idx] != 2'b00) ctr_d[upd_idx] = ctr_q[upd_idx] - 2'b01;
                end
            end else if (bp.upd_taken) begin
                touch                = 1'b1;
                touch_idx            = victim_idx;
                valid_d[victim_idx]  = 1'b1;
                tag_d[victim_idx]    = upd_tag;
                target_d[victim_idx] = bp.upd_target;
                ctr_d[victim_idx]    = 2'b10;
            end
        end
        touch_age = age_q[touch_idx];
        // Younger-than-touched entries age by one; ages stay a permutation.
        if (touch) begin
            for (int unsigned i = 0; i < LINE_NUM; i++) begin
                if (IDX_W'(i) == touch_idx) begin
                    age_d[i] = '0;
                end else if (age_q[i] < touch_age) begin
                    age_d[i] = age_q[i] + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < LINE_NUM; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b10;
                age_q[i]    <= IDX_W'(i);
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
            age_q    <= age_d;
        end
    end
endmodule

// File: tb/tb_assoc_branch_predictor.sv
// Directed self-checking bench for assoc_branch_predictor (LINE_NUM=4,
// TAG_WIDTH=10). Expected values are hand-derived from the LRU/counter rules.
module tb_assoc_branch_predictor;
    logic clk = 1'b0;
    logic rst, en, flush;
    int   n_tests = 0;
    int   n_fail  = 0;

    assoc_branch_predictor_if #(.DATA_WIDTH(32)) bp_if ();

    assoc_branch_predictor #(
        .DATA_WIDTH(32),
        .LINE_NUM  (4),
        .TAG_WIDTH (10)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .flush(flush),
        .bp   (bp_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        bp_if.upd_valid  = 1'b1;
        bp_if.upd_pc     = pc;
        bp_if.upd_taken  = taken;
        bp_if.upd_target = tgt;
        tick();
        bp_if.upd_valid  = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] tgt);
        bp_if.lookup_pc = pc;
        #1;
        check({tag, ".hit"},    32'(bp_if.pred_hit),   32'(hit));
        check({tag, ".taken"},  32'(bp_if.pred_taken), 32'(taken));
        check({tag, ".target"}, bp_if.pred_target,     tgt);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0;
        bp_if.lookup_pc  = 32'h100;
        bp_if.upd_valid  = 1'b0;
        bp_if.upd_pc     = '0;
        bp_if.upd_taken  = 1'b0;
        bp_if.upd_target = '0;
        tick();
        tick();
        look("in_rst", 32'h100, 1'b0, 1'b0, 32'h104);
        rst = 1'b0;
        look("post_rst", 32'h100, 1'b0, 1'b0, 32'h104);

        // Counter walk on entry for 0x100
        upd(32'h100, 1'b1, 32'h200);
        look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
        upd(32'h100, 1'b0, 32'h0);
        look("ctr01", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 32'h0);             // 00 saturates
        upd(32'h100, 1'b1, 32'h300);           // 01
        look("ctr_sat0", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h300);           // 10
        look("ctr10", 32'h100, 1'b1, 1'b1, 32'h300);
        upd(32'h100, 1'b1, 32'h300);           // 11
        upd(32'h100, 1'b1, 32'h300);           // stays 11
        look("ctr_sat3", 32'h100, 1'b1, 1'b1, 32'h300);
        upd(32'h100, 1'b0, 32'h0);             // 10
        look("ctr_dn10", 32'h100, 1'b1, 1'b1, 32'h300);
        upd(32'h100, 1'b0, 32'h0);             // 01
        look("ctr_dn01", 32'h100, 1'b1, 1'b0, 32'h104);

        // LRU replacement
        rst = 1'b1; tick(); rst = 1'b0;
        upd(32'h10, 1'b1, 32'h1000);           // e0, ages [0,1,2,3]
        upd(32'h20, 1'b1, 32'h2000);           // e1, [1,0,2,3]
        upd(32'h30, 1'b1, 32'h3000);           // e2, [2,1,0,3]
        upd(32'h40, 1'b1, 32'h4000);           // e3, [3,2,1,0]
        upd(32'h10, 1'b1, 32'h1000);           // hit e0, [0,3,2,1]
        upd(32'h50, 1'b1, 32'h5000);           // evict e1, [1,0,3,2]
        look("lru_20", 32'h20, 1'b0, 1'b0, 32'h24);
        look("lru_10", 32'h10, 1'b1, 1'b1, 32'h1000);
        look("lru_50", 32'h50, 1'b1, 1'b1, 32'h5000);
        look("lru_40", 32'h40, 1'b1, 1'b1, 32'h4000);

        // Not-taken miss leaves table and ages alone
        upd(32'h60, 1'b0, 32'h6000);
        look("nt_miss", 32'h60, 1'b0, 1'b0, 32'h64);
        upd(32'h90, 1'b1, 32'h9000);           // evicts e2 (0x30) only if ages untouched
        look("age_30", 32'h30, 1'b0, 1'b0, 32'h34);
        look("age_40", 32'h40, 1'b1, 1'b1, 32'h4000);
        look("age_90", 32'h90, 1'b1, 1'b1, 32'h9000);

        // Flush beats a same-cycle update
        flush = 1'b1;
        upd(32'h70, 1'b1, 32'h7000);
        flush = 1'b0;
        look("fl_10", 32'h10, 1'b0, 1'b0, 32'h14);
        look("fl_90", 32'h90, 1'b0, 1'b0, 32'h94);
        look("fl_70", 32'h70, 1'b0, 1'b0, 32'h74);

        // en=0 blocks allocation and counter updates
        upd(32'hB0, 1'b1, 32'hB000);
        en = 1'b0;
        upd(32'hA0, 1'b1, 32'hA000);
        upd(32'hB0, 1'b0, 32'h0);
        upd(32'hB0, 1'b0, 32'h0);
        en = 1'b1;
        look("en_A0", 32'hA0, 1'b0, 1'b0, 32'hA4);
        look("en_B0", 32'hB0, 1'b1, 1'b1, 32'hB000);

        // No bypass: same-cycle lookup sees pre-edge state
        bp_if.upd_valid  = 1'b1;
        bp_if.upd_pc     = 32'h80;
        bp_if.upd_taken  = 1'b1;
        bp_if.upd_target = 32'h8000;
        look("byp_pre", 32'h80, 1'b0, 1'b0, 32'h84);
        tick();
        bp_if.upd_valid  = 1'b0;
        look("byp_post", 32'h80, 1'b1, 1'b1, 32'h8000);

        // Reset discards a same-cycle update
        rst = 1'b1;
        upd(32'hC0, 1'b1, 32'hC000);
        rst = 1'b0;
        look("rst_C0", 32'hC0, 1'b0, 1'b0, 32'hC4);
        look("rst_80", 32'h80, 1'b0, 1'b0, 32'h84);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
